// File: rtl/usb_crc_pkg.sv
// Shared definitions for the USB CRC16 transmit path.
//   crc_state_t      : appender FSM states
//   CRC16_SEED       : register preset loaded at the start of every packet
//   CRC16_POLY       : generator polynomial x^16 + x^15 + x^2 + 1 (x^16 implicit)
//   CRC16_RESIDUAL   : remainder a receiver sees after data + inverted CRC
package usb_crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_CRC,
        ST_DONE
    } crc_state_t;

    localparam logic [15:0] CRC16_SEED     = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/tx_crc16_appender_if.sv
// Bit-level link between a serial payload source, the CRC appender and the
// downstream bit-stuffer.
//   start, bit_strobe, payload_bit, data_end : source -> appender
//   tx_bit, crc_active, busy, crc_done, crc_err : appender -> stuffer/status
// modport master : the payload source side
// modport slave  : the appender side
interface tx_crc16_appender_if;

    logic start;
    logic bit_strobe;
    logic payload_bit;
    logic data_end;
    logic tx_bit;
    logic crc_active;
    logic busy;
    logic crc_done;
    logic crc_err;

    modport master (
        output start, bit_strobe, payload_bit, data_end,
        input  tx_bit, crc_active, busy, crc_done, crc_err
    );

    modport slave (
        input  start, bit_strobe, payload_bit, data_end,
        output tx_bit, crc_active, busy, crc_done, crc_err
    );

endinterface

// File: rtl/crc16_step.sv
// One serial step of CRC16 (poly 0x8005), MSB-side feedback.
//   crc_in  : current register value
//   bit_in  : serial bit being absorbed
//   crc_out : register value after absorbing bit_in
module crc16_step
    import usb_crc_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic fb;

    assign fb      = crc_in[15] ^ bit_in;
    assign crc_out = {crc_in[14:0], 1'b0} ^ (fb ? CRC16_POLY : '0);

endmodule

// File: rtl/tx_crc16_appender.sv
// Serial CRC16 appender: passes payload bits through while accumulating the
// CRC, then emits the inverted remainder MSB first, 16 strobes long.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : tx_crc16_appender_if.slave (start/bit_strobe/payload_bit/data_end in,
//          tx_bit/crc_active/busy/crc_done/crc_err out)
// Build option TX_CRC_SELFCHECK_EN: adds a receiver-style checker fed with
// every strobed tx_bit; crc_err flags a wrong residual in DONE. Without it
// crc_err is tied low.
module tx_crc16_appender
    import usb_crc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    tx_crc16_appender_if.slave bus
);

    crc_state_t  state, state_nxt;
    logic [15:0] crc, crc_nxt, crc_step;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic        tx_bit;

    crc16_step u_crc_step (
        .crc_in  (crc),
        .bit_in  (bus.payload_bit),
        .crc_out (crc_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            crc     <= CRC16_SEED;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            crc     <= crc_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        crc_nxt     = crc;
        bit_cnt_nxt = bit_cnt;
        if (bus.start) begin
            // start overrides everything, including a strobe in the same cycle
            state_nxt   = ST_DATA;
            crc_nxt     = CRC16_SEED;
            bit_cnt_nxt = '0;
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_DATA: begin
                    // a strobe coinciding with data_end is still absorbed
                    if (bus.bit_strobe) crc_nxt = crc_step;
                    if (bus.data_end)   state_nxt = ST_CRC;
                end
                ST_CRC: begin
                    if (bus.bit_strobe) begin
                        crc_nxt     = {crc[14:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) state_nxt = ST_DONE;
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_bit = 1'b0;
        unique case (state)
            ST_DATA: tx_bit = bus.payload_bit;
            ST_CRC:  tx_bit = ~crc[15];
            default: tx_bit = 1'b0;
        endcase
    end

    assign bus.tx_bit     = tx_bit;
    assign bus.crc_active = (state == ST_CRC);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.crc_done   = (state == ST_DONE);

`ifdef TX_CRC_SELFCHECK_EN
    logic [15:0] chk, chk_step;
    logic        err_q;
    logic        chk_bad;

    crc16_step u_chk_step (
        .crc_in  (chk),
        .bit_in  (tx_bit),
        .crc_out (chk_step)
    );

    assign chk_bad = (state == ST_DONE) && (chk != CRC16_RESIDUAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk   <= CRC16_SEED;
            err_q <= 1'b0;
        end else if (bus.start) begin
            chk   <= CRC16_SEED;
            err_q <= 1'b0;
        end else begin
            if (bus.bit_strobe && (state == ST_DATA || state == ST_CRC))
                chk <= chk_step;
            if (chk_bad)
                err_q <= 1'b1;
        end
    end

    // visible already during DONE, then held by err_q until start/reset
    assign bus.crc_err = err_q | chk_bad;
`else
    assign bus.crc_err = 1'b0;
`endif

endmodule

// File: doc/tx_crc16_appender.md
TX_CRC16_APPENDER -- requirements
Module: tx_crc16_appender

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begin a new packet data phase.
REQ-004 SHALL have port bit_strobe, input, 1 bit: one-cycle pulse per transmitted bit time.
REQ-005 SHALL have port payload_bit, input, 1 bit: serial payload bit, LSB-first, before bit stuffing.
REQ-006 SHALL have port data_end, input, 1 bit: the current or most recent strobed bit is the last payload bit.
REQ-007 SHALL have port tx_bit, output, 1 bit: serial bit to the bit-stuffer.
REQ-008 SHALL have port crc_active, output, 1 bit: high while CRC bits are being emitted.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port crc_done, output, 1 bit: one-cycle pulse after the 16th CRC bit.
REQ-011 SHALL have port crc_err, output, 1 bit: self-check mismatch flag (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, DATA, CRC and DONE.
REQ-013 SHALL perform these transitions: IDLE->DATA on start; DATA->CRC on data_end; CRC->DONE on the 16th bit_strobe in CRC; DONE->IDLE unconditionally after 1 cycle.
REQ-014 SHALL load the 16-bit CRC register with 0xFFFF on start.
REQ-015 SHALL, in DATA on bit_strobe, update the CRC register with polynomial 0x8005 using feedback fb = crc[15]^payload_bit: next[0]=fb, next[2]=crc[1]^fb, next[15]=crc[14]^fb, all other bits shift left by one.
REQ-016 SHALL, when data_end and bit_strobe are asserted in the same cycle in DATA, include that bit in the CRC before entering CRC.
REQ-017 SHALL drive tx_bit combinationally: payload_bit in DATA, ~crc[15] in CRC, and 0 otherwise.
REQ-018 SHALL, in CRC on bit_strobe, shift the CRC register left with zero fill and increment a 4-bit counter; the inverted remainder is thereby emitted MSB first.
REQ-019 SHALL treat the strobe that sees counter value 15 as the 16th CRC bit: the counter wraps to 0 and the FSM enters DONE.
REQ-020 SHALL assert crc_active only in CRC and crc_done only in DONE.
REQ-021 SHALL, when start is asserted in DATA, CRC or DONE, abort the current packet, reseed to 0xFFFF, clear the counter and enter DATA; start has priority over all other inputs.
REQ-022 SHALL accept a zero-length payload: start followed by data_end with no strobes emits 16 zero bits.
REQ-023 SHALL hold all state in the absence of bit_strobe; data_end outside DATA has no effect.

Reset
REQ-024 SHALL, on rst assertion, immediately and asynchronously set the FSM to IDLE, the CRC register to 0xFFFF, the counter to 0, crc_err to 0 and the checker register (if present) to 0xFFFF.
REQ-025 SHALL hold tx_bit, crc_active, busy and crc_done at 0 while in reset, including when reset is asserted mid-CRC.

Configuration
REQ-026 SHALL, when macro TX_CRC_SELFCHECK_EN is defined, include a second CRC register seeded 0xFFFF on start that is fed every strobed tx_bit in DATA and CRC.
REQ-027 SHALL, with TX_CRC_SELFCHECK_EN defined, set crc_err in DONE if the checker residual is not 0x800D; crc_err stays set until the next start or reset.
REQ-028 SHALL, when TX_CRC_SELFCHECK_EN is not defined, omit the checker register and tie crc_err to 0.

Structure
REQ-029 SHALL place the state enum, CRC16_SEED (0xFFFF), CRC16_POLY (0x8005) and CRC16_RESIDUAL (0x800D) in the shared package usb_crc_pkg.
REQ-030 SHALL implement the per-bit CRC update once as sub-module crc16_step (combinational: crc_in, bit_in -> crc_out), instantiated for the main register and for the checker.

Verification
REQ-031 SHALL cover zero-length payload: start, then data_end, then 16 strobes -> tx_bit 0 on all 16, crc_done pulses 1 cycle after the 16th strobe, crc_err=0.
REQ-032 SHALL cover random 8..1024-bit payloads compared against a reference model: emitted CRC equals ~CRC16(payload); a receiver model's residual is 0x800D.
REQ-033 SHALL cover simultaneous events: data_end with bit_strobe on the last payload bit -> that bit is included, and the next strobe emits the first CRC bit.
REQ-034 SHALL cover restart: start asserted after 5 CRC bits -> FSM in DATA, CRC register = 0xFFFF, counter = 0, no crc_done.
REQ-035 SHALL cover reset: rst asserted mid-CRC -> all outputs 0 within the same cycle; the next packet after release is correct.
REQ-036 SHALL cover the self-check (macro defined): force one CRC register bit flip -> crc_err=1 in DONE; it clears on the next start.
